// File: rtl/baccarat_sequencer.sv
// Baccarat round controller: one card load per slow_clock edge,
// third-card rules on datapath scores, then win lights in DONE.
module baccarat_sequencer #(
  parameter logic [3:0] NATURAL      = 4'd8,
  parameter logic [3:0] PLAYER_STAND = 4'd6
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
    CHECK, DEAL_P3, P3_EVAL, DEAL_D3, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] v;
  logic       d_draw;

  // Dealer draw decision once the player has taken a third card
  always_comb begin
    v      = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    d_draw = 1'b0;
    unique case (1'b1)
      (dscore <= 4'd2): d_draw = 1'b1;
      (dscore == 4'd3): d_draw = (v != 4'd8);
      (dscore == 4'd4): d_draw = (v >= 4'd2) && (v <= 4'd7);
      (dscore == 4'd5): d_draw = (v >= 4'd4) && (v <= 4'd7);
      (dscore == 4'd6): d_draw = (v >= 4'd6) && (v <= 4'd7);
      default:          d_draw = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) state_q <= DEAL_P1;
    else       state_q <= state_d;
  end

  // Next state and Moore outputs
  always_comb begin
    state_d          = state_q;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    round_done       = 1'b0;
    unique case (state_q)
      DEAL_P1: begin
        load_pcard1 = 1'b1;
        state_d     = DEAL_D1;
      end
      DEAL_D1: begin
        load_dcard1 = 1'b1;
        state_d     = DEAL_P2;
      end
      DEAL_P2: begin
        load_pcard2 = 1'b1;
        state_d     = DEAL_D2;
      end
      DEAL_D2: begin
        load_dcard2 = 1'b1;
        state_d     = CHECK;
      end
      CHECK: begin
        if (pscore >= NATURAL || dscore >= NATURAL)
          state_d = DONE;
        else if (pscore < PLAYER_STAND)
          state_d = DEAL_P3;
        else if (dscore <= 4'd5)
          state_d = DEAL_D3;
        else
          state_d = DONE;
      end
      DEAL_P3: begin
        load_pcard3 = 1'b1;
        state_d     = P3_EVAL;
      end
      P3_EVAL: begin
        state_d = d_draw ? DEAL_D3 : DONE;
      end
      DEAL_D3: begin
        load_dcard3 = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        round_done       = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: state_d = DEAL_P1;
    endcase
  end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Bench for baccarat_sequencer: card-register datapath model plus
// a rule-level round model checked every cycle.
module tb_baccarat_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       lp1, lp2, lp3, ld1, ld2, ld3;
  logic       plw, dlw, done;

  int errors = 0;
  int checks = 0;

  baccarat_sequencer dut (
    .slow_clock       (clk),
    .reset            (reset),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (plw),
    .dealer_win_light (dlw),
    .round_done       (done)
  );

  always #5 clk = ~clk;

  // deck order: p1, d1, p2, d2, p3, d3
  int deck [6];
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

  function automatic int val(int c);
    return (c >= 10) ? 0 : c;
  endfunction

  // Card registers as the real datapath would hold them
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc1 <= 0; pc2 <= 0; pc3 <= 0;
      dc1 <= 0; dc2 <= 0; dc3 <= 0;
    end else begin
      if (lp1) pc1 <= 4'(deck[0]);
      if (ld1) dc1 <= 4'(deck[1]);
      if (lp2) pc2 <= 4'(deck[2]);
      if (ld2) dc2 <= 4'(deck[3]);
      if (lp3) pc3 <= 4'(deck[4]);
      if (ld3) dc3 <= 4'(deck[5]);
    end
  end

  always_comb begin
    pscore = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
    dscore = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
    pcard3 = pc3;
  end

  // Expected word per step: {p1,p2,p3,d1,d2,d3,plight,dlight,done}
  localparam logic [8:0] W_P1 = 9'b100_000_000;
  localparam logic [8:0] W_P2 = 9'b010_000_000;
  localparam logic [8:0] W_P3 = 9'b001_000_000;
  localparam logic [8:0] W_D1 = 9'b000_100_000;
  localparam logic [8:0] W_D2 = 9'b000_010_000;
  localparam logic [8:0] W_D3 = 9'b000_001_000;
  localparam logic [8:0] W_IDLE = 9'b0;

  // Dealer draws for third-card value v when bit v of mask is set
  logic [9:0] draw_mask [8] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF,
                                10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

  logic [8:0] exp_tbl [12];
  int         done_idx;
  int         step;
  bit         chk_en = 1'b0;

  task automatic build_model();
    logic [8:0] q[$];
    int ps, ds, pf, df;
    bit nat, pd, dd;
    ps  = (val(deck[0]) + val(deck[2])) % 10;
    ds  = (val(deck[1]) + val(deck[3])) % 10;
    nat = (ps >= 8) || (ds >= 8);
    pd  = !nat && (ps < 6);
    if (nat)     dd = 0;
    else if (!pd) dd = (ds <= 5);
    else         dd = draw_mask[ds][val(deck[4])];
    q = '{W_P1, W_D1, W_P2, W_D2, W_IDLE};
    if (pd) begin
      q.push_back(W_P3);
      q.push_back(W_IDLE);
    end
    if (dd) q.push_back(W_D3);
    done_idx = q.size();
    pf = (ps + (pd ? val(deck[4]) : 0)) % 10;
    df = (ds + (dd ? val(deck[5]) : 0)) % 10;
    while (q.size() < 12)
      q.push_back({6'b0, pf >= df, df >= pf, 1'b1});
    for (int i = 0; i < 12; i++) exp_tbl[i] = q[i];
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset)         step <= 0;
    else if (step < 11) step <= step + 1;
  end

  // Compare DUT against model on every cycle of a round
  always @(negedge clk) begin
    if (chk_en)
      chk($sformatf("step%0d", step),
          int'({lp1, lp2, lp3, ld1, ld2, ld3, plw, dlw, done}),
          int'(exp_tbl[step]));
  end

  task automatic start_round(int p1, int d1, int p2, int d2,
                             int p3, int d3);
    @(negedge clk);
    #1;
    deck = '{p1, d1, p2, d2, p3, d3};
    build_model();
    reset = 1'b1;
    #1;
    chk("reset_outs",
        int'({lp1, lp2, lp3, ld1, ld2, ld3, plw, dlw, done}),
        int'(W_P1));
    #1 reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic run_round(int p1, int d1, int p2, int d2,
                           int p3, int d3,
                           int done_lit, bit pl_lit, bit dl_lit);
    start_round(p1, d1, p2, d2, p3, d3);
    repeat (11) @(posedge clk);
    @(negedge clk);
    #2;
    chk("model_done_edge", done_idx, done_lit);
    chk("round_done", int'(done), 1);
    chk("player_light", int'(plw), int'(pl_lit));
    chk("dealer_light", int'(dlw), int'(dl_lit));
  endtask

  initial begin
    deck = '{0, 0, 0, 0, 0, 0};
    // natural
    run_round(3, 1, 5, 9, 4, 4, 5, 1, 0);
    // player stands 7, dealer 3 draws 2 -> 5
    run_round(3, 1, 4, 2, 9, 2, 6, 1, 0);
    // both hands 3, pcard3 8 -> dealer stands
    run_round(2, 3, 1, 10, 8, 5, 7, 0, 1);
    // pcard3 7 -> dealer draws 7, tie at 0
    run_round(2, 3, 1, 10, 7, 7, 8, 1, 1);
    // dealer 6, king as third -> stands
    run_round(1, 6, 1, 13, 13, 5, 7, 0, 1);
    // dealer 6, pcard3 6 -> draws 1; player 8 vs 7
    run_round(1, 6, 1, 13, 6, 1, 8, 1, 0);
    // reset while in DEAL_P3
    start_round(2, 3, 1, 10, 7, 7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    chk("in_deal_p3", int'(lp3), 1);
    chk_en = 1'b0;
    // fresh round after abandon, then reset from DONE on next round
    run_round(2, 3, 1, 10, 8, 5, 7, 0, 1);
    // sweep dealer 0..7 x pcard3 1..13
    for (int d = 0; d < 8; d++)
      for (int c = 1; c <= 13; c++) begin
        start_round(1, d, 1, 10, c, 5);
        repeat (11) @(posedge clk);
      end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
